// File: rtl/m_store_sequencer.sv
// Store sequencer: turns one LSU store into one or two aligned data-bus write beats
// and reports done, fault (bus error, timeout, illegal funct3) or misalignment.
module m_store_sequencer #(
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYC      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_func3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_byte_en,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic        dbus_err,
  output logic        st_done,
  output logic        st_fault,
  output logic        st_misaligned
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, REPORT} state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  en_q, en_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] b1_addr_q, b1_addr_d;
  logic [3:0]  b1_en_q, b1_en_d;
  logic [31:0] b1_data_q, b1_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        mis_q, mis_d;

  logic [1:0]  off;
  logic [7:0]  base_mask;
  logic [31:0] masked_data;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        illegal_f3;
  logic        is_misaligned;
  logic        timed_out;

  // Lane placement of the incoming store across a two-word window.
  always_comb begin
    off         = st_addr[1:0];
    base_mask   = 8'h00;
    masked_data = 32'h0;
    case (st_func3)
      3'd0: begin base_mask = 8'h01; masked_data = {24'h0, st_data[7:0]};  end
      3'd1: begin base_mask = 8'h03; masked_data = {16'h0, st_data[15:0]}; end
      3'd2: begin base_mask = 8'h0F; masked_data = st_data;                end
      default: ;
    endcase
    mask8         = base_mask << off;
    data64        = {32'h0, masked_data} << {off, 3'b000};
    illegal_f3    = (st_func3 > 3'd2);
    is_misaligned = ((st_func3 == 3'd1) && off[0]) ||
                    ((st_func3 == 3'd2) && (off != 2'd0));
  end

  assign timed_out = (({1'b0, cnt_q} + 9'd1) == TIMEOUT_LIM);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    en_d      = en_q;
    wdata_d   = wdata_q;
    b1_addr_d = b1_addr_q;
    b1_en_d   = b1_en_q;
    b1_data_d = b1_data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (illegal_f3) begin
            fault_d = 1'b1;
            state_d = REPORT;
          end else if (!SPLIT_MISALIGNED && is_misaligned) begin
            mis_d   = 1'b1;
            state_d = REPORT;
          end else begin
            state_d   = BEAT0;
            req_d     = 1'b1;
            addr_d    = {st_addr[31:2], 2'b00};
            en_d      = mask8[3:0];
            wdata_d   = data64[31:0];
            b1_addr_d = {st_addr[31:2], 2'b00} + 32'd4;
            b1_en_d   = mask8[7:4];
            b1_data_d = data64[63:32];
            cnt_d     = 8'd0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (dbus_ack && !dbus_err && (state_q == BEAT0) && (b1_en_q != 4'h0)) begin
          state_d = BEAT1;
          addr_d  = b1_addr_q;
          en_d    = b1_en_q;
          wdata_d = b1_data_q;
          cnt_d   = 8'd0;
        end else if (dbus_ack || timed_out) begin
          // An ack in the timeout cycle still counts as a real response.
          done_d  = dbus_ack && !dbus_err;
          fault_d = !(dbus_ack && !dbus_err);
          state_d = REPORT;
          req_d   = 1'b0;
          addr_d  = 32'h0;
          en_d    = 4'h0;
          wdata_d = 32'h0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= 32'h0;
      en_q      <= 4'h0;
      wdata_q   <= 32'h0;
      b1_addr_q <= 32'h0;
      b1_en_q   <= 4'h0;
      b1_data_q <= 32'h0;
      cnt_q     <= 8'd0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      wdata_q   <= wdata_d;
      b1_addr_q <= b1_addr_d;
      b1_en_q   <= b1_en_d;
      b1_data_q <= b1_data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      mis_q     <= mis_d;
    end
  end

  assign st_ready      = (state_q == IDLE);
  assign dbus_req      = req_q;
  assign dbus_we       = req_q;
  assign dbus_addr     = addr_q;
  assign dbus_byte_en  = en_q;
  assign dbus_wdata    = wdata_q;
  assign st_done       = done_q;
  assign st_fault      = fault_q;
  assign st_misaligned = mis_q;

endmodule

// File: doc/m_store_sequencer.md
# m_store_sequencer

Sequences data-memory stores from the LSU onto the data bus. It accepts one store per handshake and computes byte enables and lane-aligned write data. Stores that cross a word boundary are split into two aligned bus beats. The block then drives the request/acknowledge bus protocol and reports completion, bus fault, timeout or misalignment back to the pipeline, which stalls on `st_ready`.

## Interface
- `SPLIT_MISALIGNED`, default 1: 1 = split word-crossing stores into two beats; 0 = any non-naturally-aligned store is rejected with `st_misaligned`.
- `TIMEOUT_CYC`, default 64: cycles a beat may wait for `dbus_ack` before the store is faulted (range 1..255).
- `clk` in 1: sole clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `st_valid` in 1: store request valid.
- `st_ready` out 1: sequencer idle and able to accept.
- `st_func3` in 3: RISC-V store funct3 (0 = sb, 1 = sh, 2 = sw).
- `st_addr` in 32: byte address.
- `st_data` in 32: store data, right-justified.
- `dbus_req` out 1: bus write request.
- `dbus_we` out 1: write enable, equal to `dbus_req`.
- `dbus_addr` out 32: word-aligned beat address (bits [1:0] = 0).
- `dbus_byte_en` out 4: per-lane write enable.
- `dbus_wdata` out 32: lane-aligned data; lanes with byte_en = 0 are driven 0.
- `dbus_ack` in 1: single-cycle beat acknowledge, meaningful only while `dbus_req` = 1.
- `dbus_err` in 1: qualifies `dbus_ack` as an error response.
- `st_done` out 1: one-cycle pulse on successful completion.
- `st_fault` out 1: one-cycle pulse on bus error, timeout or illegal func3.
- `st_misaligned` out 1: one-cycle pulse on rejected misaligned store (only when SPLIT_MISALIGNED = 0).

## Operation
- States: IDLE, BEAT0, BEAT1, REPORT. `st_ready` = (state == IDLE).
- Accept occurs when `st_valid` and `st_ready` are both 1. On accept, register func3, address, data and the computed mask/data.
- With `off` = `st_addr[1:0]`, the 8-bit mask is 0x01 << off for sb, 0x03 << off for sh, and 0x0F << off for sw.
- The 64-bit data is the masked `st_data` shifted left by 8*off.
- Beat0 uses address `st_addr & ~3`, mask[3:0] and data[31:0].
- Beat1 is needed iff mask[7:4] != 0. It uses beat0 address + 4, mask[7:4] and data[63:32]. Address addition wraps modulo 2^32.
- func3 3..7 on accept: no bus activity. Go to REPORT and pulse `st_fault`.
- SPLIT_MISALIGNED = 0 with a misaligned store (sh with off[0] = 1, or sw with off != 0): no bus activity. Go to REPORT and pulse `st_misaligned`.
- SPLIT_MISALIGNED = 1: sh at off 1 is a single beat with byte_en 0110. Only word-crossing stores use two beats.
- BEAT0 / BEAT1: `dbus_req` = 1, and addr/byte_en/wdata are held stable until a cycle with `dbus_ack` = 1.
  - Ack with `dbus_err` = 1: abort, skip any remaining beat, go to REPORT with fault.
  - Ack on BEAT0 with beat1 needed: go to BEAT1.
  - Otherwise: go to REPORT with done.
- Timeout counter: cleared on entry to each beat and incremented each cycle without ack. When it reaches TIMEOUT_CYC, deassert `dbus_req`, go to REPORT with fault, and skip beat1. An ack arriving in the same cycle as the timeout wins.
- REPORT: pulse exactly one of `st_done` / `st_fault` / `st_misaligned`, then return to IDLE.
- Reset during any state: return to IDLE immediately. `dbus_req` drops asynchronously and no status pulse is produced for the aborted store.

## Timing
- Reset values:
  - `st_ready` = 1.
  - `dbus_req`, `dbus_we`, `st_done`, `st_fault`, `st_misaligned` = 0.
  - `dbus_addr`, `dbus_byte_en`, `dbus_wdata` = 0.
  - Timeout counter = 0.
- Accept at cycle T: `dbus_req` rises at T+1.
- Zero-wait single beat (ack at T+1): status pulse at T+2, `st_ready` back to 1 at T+3. Minimum store-to-store spacing is 3 cycles.
- Split store: BEAT1 starts the cycle after the beat0 ack. `dbus_req` stays high continuously across the two beats while the address/enable/data change.
- Rejected store (illegal or misaligned): status pulse at T+1, `st_ready` = 1 at T+2.
- Bus outputs return to 0 in any cycle where `dbus_req` = 0.

## Test plan
- sb, addr 0x1003, data 0x000000AB, ack at T+1 -> one beat: addr 0x1000, byte_en 1000, wdata 0xAB000000; `st_done` at T+2.
- sw, addr 0x2002, data 0x11223344, SPLIT = 1, zero-wait acks -> beat0 (0x2000, 1100, 0x33440000), then beat1 (0x2004, 0011, 0x00001122), `dbus_req` high for 2 consecutive cycles, one `st_done` pulse.
- sh, addr 0x3001, SPLIT = 0 -> no `dbus_req`, `st_misaligned` pulse at T+1. Same stimulus with SPLIT = 1 -> single beat, byte_en 0110.
- sw, addr 0x4000, ack never returned, TIMEOUT_CYC = 4 -> `dbus_req` high exactly 4 cycles, then `st_fault` pulse, no `st_done`.
- sw, addr 0x5003 split, ack+err on beat0 -> no beat1 issued (addr 0x5004 never driven), `st_fault` pulse. Separately, func3 = 5 -> `st_fault`, no bus activity.
- Assert `rst` mid-BEAT1 with `st_valid` held high -> `dbus_req` drops asynchronously, no status pulse. After release, the next store is accepted in the first cycle.
